z80_uart_io_responder: RTL and testbench



---
 rtl/z80_uart_io_responder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_z80_uart_io_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_uart_io_responder.sv
// Z80 I/O-port responder for the UART: data, status and control ports in the CPU I/O space.
// Latency: wait_n is held low for WAIT_CYCLES clocks, starting two clocks after the strobes go active.
// Backpressure: a data-port write stalls in WAIT while tx_valid is high. RX bytes that arrive when the FIFO is full are dropped.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   a, di, dout, dout_oe  CPU address, write data, read data and read-data mux enable
//   iorq_n/rd_n/wr_n/m1_n CPU strobes (registered once on entry)
//   wait_n, int_n         CPU wait request and interrupt request (both active low)
//   tx_data/tx_valid/tx_ready  byte handoff to the UART transmitter
//   rx_data/rx_valid      single-cycle strobe from the UART receiver
// Optional build macro Z80_UART_IRQ_EN enables the control register at BASE_PORT+2 and drives int_n.
module z80_uart_io_responder #(
   parameter logic [7:0] BASE_PORT     = 8'h38,
   parameter int         RX_DEPTH_LOG2 = 4,
   parameter int         WAIT_CYCLES   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] a,
   input  logic [7:0]  di,
   output logic [7:0]  dout,
   output logic        dout_oe,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        m1_n,
   output logic        wait_n,
   output logic        int_n,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid
);

   localparam int DEPTH = 1 << RX_DEPTH_LOG2;
   localparam logic [RX_DEPTH_LOG2:0] FULL_CNT = (RX_DEPTH_LOG2+1)'(DEPTH);
   localparam logic [1:0] PORT_DATA = 2'd0;
   localparam logic [1:0] PORT_STAT = 2'd1;
   localparam logic [1:0] PORT_CTRL = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t state_q, state_d;

   // Registered CPU strobes and bus
   logic       iorq_n_q, rd_n_q, wr_n_q, m1_n_q;
   logic [7:0] a_q, di_q;
   logic       sel_prev_q;

   // Access context captured at the access edge
   logic       acc_rd_q, acc_rd_d;
   logic [1:0] acc_port_q, acc_port_d;
   logic [3:0] cnt_q, cnt_d;

   // Datapath registers
   logic [7:0] dout_q, dout_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_valid_q, tx_valid_d;
   logic       ovf_q, ovf_d;
   logic       int_q, int_d;

   // RX FIFO
   logic [7:0]               mem [DEPTH];
   logic [RX_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [RX_DEPTH_LOG2:0]   count_q, count_d;

`ifdef Z80_UART_IRQ_EN
   logic [1:0] ctrl_q, ctrl_d;
`endif

   logic [7:0] off;
   logic       sel_now, access_edge;
   logic       cnt_done, wr_blocked, finish;
   logic       rx_empty, rx_full, pop, push, drop;
   logic       tx_load;
   logic [7:0] rd_val;
   logic       unused_hi;

   assign unused_hi = ^a[15:8];

   // Offset into the port block; unsigned wrap makes one compare cover both bounds.
   assign off     = a_q - BASE_PORT;
   assign sel_now = !iorq_n_q && m1_n_q && (!rd_n_q || !wr_n_q) && (off < 8'd3);
   assign access_edge = sel_now && !sel_prev_q;

   assign rx_empty = (count_q == '0);
   assign rx_full  = (count_q == FULL_CNT);

   // The counter is loaded with WAIT_CYCLES on entry to WAIT and decrements once per cycle.
   // The countdown is complete in the cycle where the counter steps from 1 to 0, so WAIT lasts exactly WAIT_CYCLES clocks.
   assign cnt_done   = (cnt_q <= 4'd1);
   assign wr_blocked = !acc_rd_q && (acc_port_q == PORT_DATA) && tx_valid_q;
   assign finish     = (state_q == S_WAIT) && cnt_done && !wr_blocked;

   assign pop     = finish && acc_rd_q && (acc_port_q == PORT_DATA) && !rx_empty;
   assign push    = rx_valid && (!rx_full || pop);
   assign drop    = rx_valid && rx_full && !pop;
   assign tx_load = finish && !acc_rd_q && (acc_port_q == PORT_DATA);

   // Read data for the current access
   always_comb begin
      rd_val = 8'hFF;
      case (acc_port_q)
         PORT_DATA: rd_val = rx_empty ? 8'hFF : mem[rd_ptr_q];
         PORT_STAT: rd_val = {4'b0, rx_full, ovf_q, !tx_valid_q, !rx_empty};
`ifdef Z80_UART_IRQ_EN
         PORT_CTRL: rd_val = {6'b0, ctrl_q};
`else
         PORT_CTRL: rd_val = 8'hFF;
`endif
         default:   rd_val = 8'hFF;
      endcase
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (access_edge) state_d = S_WAIT;
         S_WAIT: if (finish)      state_d = S_HOLD;
         S_HOLD: if (!sel_now)    state_d = S_IDLE;
         default:                 state_d = S_IDLE;
      endcase
   end

   // FSM: outputs. The reset term releases wait_n and drops dout_oe as soon as reset is seen, without waiting for the clock edge.
   always_comb begin
      wait_n  = reset || (state_q != S_WAIT);
      dout_oe = !reset && (state_q == S_HOLD) && acc_rd_q;
`ifdef Z80_UART_IRQ_EN
      int_n   = int_q;
`else
      int_n   = 1'b1;
`endif
      dout     = dout_q;
      tx_data  = tx_data_q;
      tx_valid = tx_valid_q;
   end

   // Datapath next-state
   always_comb begin
      acc_rd_d   = acc_rd_q;
      acc_port_d = acc_port_q;
      cnt_d      = cnt_q;
      dout_d     = dout_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      ovf_d      = ovf_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
`ifdef Z80_UART_IRQ_EN
      ctrl_d     = ctrl_q;
`endif

      if (state_q == S_IDLE && access_edge) begin
         acc_rd_d   = !rd_n_q;
         acc_port_d = off[1:0];
         cnt_d      = 4'(WAIT_CYCLES);
      end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end

      if (finish && acc_rd_q) dout_d = rd_val;

      // A load only happens when tx_valid is low, so it never races the handshake.
      if (tx_load) begin
         tx_data_d  = di_q;
         tx_valid_d = 1'b1;
      end else if (tx_valid_q && tx_ready) begin
         tx_valid_d = 1'b0;
      end

      // A new drop in the same cycle as a status read wins, so no overflow is lost.
      if (drop)
         ovf_d = 1'b1;
      else if (finish && acc_rd_q && acc_port_q == PORT_STAT)
         ovf_d = 1'b0;

`ifdef Z80_UART_IRQ_EN
      if (finish && !acc_rd_q && acc_port_q == PORT_CTRL) ctrl_d = di_q[1:0];
`endif

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

`ifdef Z80_UART_IRQ_EN
   // The interrupt is registered, so int_n follows its condition one cycle late.
   assign int_d = !((ctrl_q[0] && !rx_empty) || (ctrl_q[1] && !tx_valid_q));
`else
   assign int_d = 1'b1;
`endif

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         iorq_n_q   <= 1'b1;
         rd_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         m1_n_q     <= 1'b1;
         a_q        <= 8'h00;
         di_q       <= 8'h00;
         sel_prev_q <= 1'b0;
         acc_rd_q   <= 1'b0;
         acc_port_q <= 2'd0;
         cnt_q      <= 4'd0;
         dout_q     <= 8'h00;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         int_q      <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
`ifdef Z80_UART_IRQ_EN
         ctrl_q     <= 2'b00;
`endif
      end else begin
         iorq_n_q   <= iorq_n;
         rd_n_q     <= rd_n;
         wr_n_q     <= wr_n;
         m1_n_q     <= m1_n;
         a_q        <= a[7:0];
         di_q       <= di;
         sel_prev_q <= sel_now;
         acc_rd_q   <= acc_rd_d;
         acc_port_q <= acc_port_d;
         cnt_q      <= cnt_d;
         dout_q     <= dout_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         ovf_q      <= ovf_d;
         int_q      <= int_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
`ifdef Z80_UART_IRQ_EN
         ctrl_q     <= ctrl_d;
`endif
      end
   end

   // FIFO storage has no reset; the count alone defines which entries are valid.
   // When the FIFO is full and a pop happens in the same cycle, the write lands in the slot being read, which has already been latched into dout.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= rx_data;
   end

endmodule

// File: tb/tb_z80_uart_io_responder.sv
module tb_z80_uart_io_responder;

   logic        clk;
   logic        reset;
   logic [15:0] a;
   logic [7:0]  di;
   logic [7:0]  dout;
   logic        dout_oe;
   logic        iorq_n, rd_n, wr_n, m1_n;
   logic        wait_n;
   logic        int_n;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;

   int vectors;
   int miscompares;
   int last_wl;
   logic [7:0] rdq[$];
   logic [7:0] txq[$];

   z80_uart_io_responder dut (
      .clk(clk), .reset(reset), .a(a), .di(di), .dout(dout), .dout_oe(dout_oe),
      .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
      .wait_n(wait_n), .int_n(int_n),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: compares each read and each TX handshake against the head of its queue.
   task automatic monitor_loop();
      logic oe_prev;
      logic [7:0] e;
      oe_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (dout_oe && !oe_prev) begin
            if (rdq.size() == 0) chk("rd_unexpected", {24'h0, dout}, 32'hDEAD);
            else begin
               e = rdq.pop_front();
               chk("rd_data", {24'h0, dout}, {24'h0, e});
            end
         end
         oe_prev = dout_oe;
         if (tx_valid && tx_ready) begin
            if (txq.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hDEAD);
            else begin
               e = txq.pop_front();
               chk("tx_data", {24'h0, tx_data}, {24'h0, e});
            end
         end
      end
   endtask

   task automatic rx_push(input logic [7:0] d);
      @(posedge clk); #1;
      rx_data = d; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic io_read(input logic [7:0] port, input logic [7:0] exp);
      int  wl;
      bit  seen;
      rdq.push_back(exp);
      @(posedge clk); #1;
      a = {8'h00, port}; iorq_n = 1'b0; rd_n = 1'b0;
      wl = 0; seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (!wait_n) wl++;
         if (dout_oe) seen = 1;
      end
      chk("rd_oe_seen", {31'h0, seen}, 32'h1);
      last_wl = wl;
      @(posedge clk); #1;
      iorq_n = 1'b1; rd_n = 1'b1;
      @(negedge clk);
      chk("rd_oe_held", {31'h0, dout_oe}, 32'h1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rd_oe_dropped", {31'h0, dout_oe}, 32'h0);
   endtask

   task automatic io_write(input logic [7:0] port, input logic [7:0] d);
      int wl;
      bit low_seen, done;
      @(posedge clk); #1;
      a = {8'h00, port}; di = d; iorq_n = 1'b0; wr_n = 1'b0;
      wl = 0; low_seen = 0; done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (!wait_n) begin wl++; low_seen = 1; end
         else if (low_seen) done = 1;
      end
      chk("wr_done", {31'h0, done}, 32'h1);
      last_wl = wl;
      @(posedge clk); #1;
      iorq_n = 1'b1; wr_n = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   // Drives an access that must not be decoded and checks that the bus stays untouched.
   task automatic io_ignored(input logic [7:0] port, input logic m1);
      bit touched;
      @(posedge clk); #1;
      a = {8'h00, port}; m1_n = m1; iorq_n = 1'b0; rd_n = 1'b0;
      touched = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (!wait_n || dout_oe) touched = 1;
      end
      chk("ignored_access", {31'h0, touched}, 32'h0);
      @(posedge clk); #1;
      iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      bit wait_seen;
      vectors = 0; miscompares = 0; last_wl = 0;
      reset = 1'b1; a = 16'h0; di = 8'h0;
      iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
      tx_ready = 1'b0; rx_data = 8'h0; rx_valid = 1'b0;
      fork monitor_loop(); join_none

      // Reset values
      repeat (3) @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_dout",     {24'h0, dout},    32'h00);
      chk("rst_dout_oe",  {31'h0, dout_oe}, 32'h0);
      chk("rst_wait_n",   {31'h0, wait_n},  32'h1);
      chk("rst_int_n",    {31'h0, int_n},   32'h1);
      chk("rst_tx_valid", {31'h0, tx_valid},32'h0);
      chk("rst_tx_data",  {24'h0, tx_data}, 32'h00);

      // Status after reset, with the wait-state length
      io_read(8'h39, 8'h02);
      chk("status_wait_len", last_wl, 32'd2);

      // RX ordering, empty read, status bit0 sequence
      rx_push(8'h41);
      rx_push(8'h42);
      io_read(8'h39, 8'h03);
      io_read(8'h38, 8'h41);
      io_read(8'h39, 8'h03);
      io_read(8'h38, 8'h42);
      io_read(8'h39, 8'h02);
      io_read(8'h38, 8'hFF);

      // Non-decoded port and INTA cycle
      io_ignored(8'h40, 1'b1);
      io_ignored(8'h38, 1'b0);

      // TX: first write lands, second stalls until the first is accepted
      txq.push_back(8'h55);
      io_write(8'h38, 8'h55);
      chk("wr_wait_len", last_wl, 32'd2);
      chk("tx_data_55", {24'h0, tx_data}, 32'h55);
      chk("tx_valid_55", {31'h0, tx_valid}, 32'h1);
      fork
         io_write(8'h38, 8'hAA);
         begin
            repeat (10) @(posedge clk);
            @(negedge clk);
            chk("wr_blocked_wait_n", {31'h0, wait_n}, 32'h0);
            @(posedge clk); #1; tx_ready = 1'b1;
            @(posedge clk); #1; tx_ready = 1'b0;
         end
      join
      chk("wr_blocked_long", {31'h0, (last_wl > 8)}, 32'h1);
      chk("tx_data_aa", {24'h0, tx_data}, 32'hAA);
      chk("tx_valid_aa", {31'h0, tx_valid}, 32'h1);
      io_read(8'h39, 8'h00);
      txq.push_back(8'hAA);
      @(posedge clk); #1; tx_ready = 1'b1;
      @(posedge clk); #1; tx_ready = 1'b0;
      io_read(8'h39, 8'h02);

      // Overflow: 17 pushes into a 16-deep FIFO; the 17th byte is dropped
      for (int i = 0; i < 17; i++) rx_push(8'h10 + 8'(i));
      io_read(8'h39, 8'h0F);
      io_read(8'h39, 8'h0B);
      for (int i = 0; i < 16; i++) io_read(8'h38, 8'h10 + 8'(i));
      io_read(8'h38, 8'hFF);
      io_read(8'h39, 8'h02);

      // Reset during the WAIT state of a data read
      rx_push(8'h77);
      @(posedge clk); #1;
      a = 16'h0038; iorq_n = 1'b0; rd_n = 1'b0;
      wait_seen = 0;
      for (int i = 0; i < 20 && !wait_seen; i++) begin
         @(negedge clk);
         if (!wait_n) wait_seen = 1;
      end
      chk("mid_reset_in_wait", {31'h0, wait_seen}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_reset_wait_n", {31'h0, wait_n}, 32'h1);
      chk("mid_reset_oe", {31'h0, dout_oe}, 32'h0);
      @(posedge clk); #1;
      iorq_n = 1'b1; rd_n = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_reset_tx_valid", {31'h0, tx_valid}, 32'h0);
      io_read(8'h39, 8'h02);
      io_read(8'h38, 8'hFF);

`ifdef Z80_UART_IRQ_EN
      // RX interrupt enable
      io_write(8'h3A, 8'h01);
      io_read(8'h3A, 8'h01);
      chk("irq_idle", {31'h0, int_n}, 32'h1);
      rx_push(8'h5A);
      @(negedge clk);
      chk("irq_late", {31'h0, int_n}, 32'h1);
      @(negedge clk);
      chk("irq_asserted", {31'h0, int_n}, 32'h0);
      io_read(8'h38, 8'h5A);
      @(negedge clk);
      chk("irq_cleared", {31'h0, int_n}, 32'h1);
`else
      // No control register: reads return FF, writes are ignored, int_n never asserts
      io_read(8'h3A, 8'hFF);
      io_write(8'h3A, 8'h03);
      io_read(8'h3A, 8'hFF);
      rx_push(8'h5A);
      begin
         bit irq_seen;
         irq_seen = 0;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!int_n) irq_seen = 1;
         end
         chk("irq_tied_high", {31'h0, irq_seen}, 32'h0);
      end
      io_read(8'h38, 8'h5A);
`endif

      repeat (4) @(posedge clk);
      chk("rdq_drained", rdq.size(), 32'd0);
      chk("txq_drained", txq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
